// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each access is sequenced IDLE -> ACCESS (-> RESP for reads) and contended decisions are counted.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                   state_reg, state_next;
   logic                     last_gnt_reg;
   logic                     owner_reg;
   logic                     we_reg;
   logic [ADDR_W-1:0]        addr_reg;
   logic [DATA_W-1:0]        wdata_reg;
   logic [CNT_W-1:0]         conflict_cnt_reg;

   logic [1:0]               req;
   logic [1:0]               we_in;
   logic [1:0][ADDR_W-1:0]   addr_in;
   logic [1:0][DATA_W-1:0]   wdata_in;
   logic [1:0]               gnt;
   logic [1:0]               rvalid;
   logic [1:0][DATA_W-1:0]   rdata;

   logic                     sel_valid;
   logic                     sel_port;
   logic                     both_req;

   assign req      = {m1_req, m0_req};
   assign we_in    = {m1_we, m0_we};
   assign addr_in  = {m1_addr, m0_addr};
   assign wdata_in = {m1_wdata, m0_wdata};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Requests are only looked at in IDLE; a tie goes to the port that did not win last time.
   always_comb begin
      state_next = state_reg;
      sel_valid  = 1'b0;
      sel_port   = 1'b0;
      both_req   = 1'b0;
      case (state_reg)
         IDLE: begin
            sel_valid = |req;
            both_req  = &req;
            sel_port  = both_req ? ~last_gnt_reg : req[1];
            if (sel_valid) state_next = ACCESS;
         end
         ACCESS:  state_next = we_reg ? IDLE : RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt_reg     <= 1'b1;
         owner_reg        <= 1'b0;
         we_reg           <= 1'b0;
         addr_reg         <= '0;
         wdata_reg        <= '0;
         conflict_cnt_reg <= '0;
      end else if (sel_valid) begin
         last_gnt_reg <= sel_port;
         owner_reg    <= sel_port;
         we_reg       <= we_in[sel_port];
         addr_reg     <= addr_in[sel_port];
         wdata_reg    <= wdata_in[sel_port];
         if (both_req && (conflict_cnt_reg != '1))
            conflict_cnt_reg <= conflict_cnt_reg + CNT_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] rdata_reg;

         // Read data is captured at the end of ACCESS and held until this port's next read.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               rdata_reg <= '0;
            else if ((state_reg == ACCESS) && !we_reg && (owner_reg == 1'(gi)))
               rdata_reg <= mem_rd;
         end

         assign gnt[gi]    = (state_reg == ACCESS) && (owner_reg == 1'(gi));
         assign rvalid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
         assign rdata[gi]  = rdata_reg;
      end
   endgenerate

   assign m0_gnt       = gnt[0];
   assign m1_gnt       = gnt[1];
   assign m0_rvalid    = rvalid[0];
   assign m1_rvalid    = rvalid[1];
   assign m0_rdata     = rdata[0];
   assign m1_rdata     = rdata[1];
   assign mem_we       = (state_reg == ACCESS) && we_reg;
   assign mem_addr     = addr_reg;
   assign mem_wd       = wdata_reg;
   assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two requester agents, a behavioural memory, and a transaction-level
// model of round-robin service (grant one cycle after a decision, read data one cycle later).
module tb_dmem_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } tx_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  req_d, we_d;
   logic [31:0] addr_d [2];
   logic [31:0] wdata_d [2];

   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd;
   logic [15:0] conflict_cnt;
   logic        s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid, s_mem_we;
   logic [31:0] s_m0_rdata, s_m1_rdata, s_mem_addr, s_mem_wd;
   logic [1:0]  s_conflict_cnt;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(req_d[0]), .m0_we(we_d[0]), .m0_addr(addr_d[0]), .m0_wdata(wdata_d[0]),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(req_d[1]), .m1_we(we_d[1]), .m1_addr(addr_d[1]), .m1_wdata(wdata_d[1]),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .conflict_cnt(conflict_cnt)
   );

   // Narrow-counter copy sharing the same stimulus, for saturation.
   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .m0_req(req_d[0]), .m0_we(we_d[0]), .m0_addr(addr_d[0]), .m0_wdata(wdata_d[0]),
      .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
      .m1_req(req_d[1]), .m1_we(we_d[1]), .m1_addr(addr_d[1]), .m1_wdata(wdata_d[1]),
      .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
      .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd), .mem_rd(mem_rd),
      .conflict_cnt(s_conflict_cnt)
   );

   logic [31:0] mem  [256];
   logic [31:0] smem [256];
   assign mem_rd = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

   int checks = 0, failures = 0, cyc = 0;
   int acc_cycle, resp_cycle, next_free, exp_cnt, go_pct;
   logic        acc_owner, acc_we, resp_owner, last_gnt;
   logic [31:0] acc_addr, acc_wdata, resp_data;
   logic [31:0] last_rdata [2];
   bit          active [2];
   bit          done_pending [2];
   tx_t         txq0 [$];
   tx_t         txq1 [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      tx_t t;
      t = '{we: we, addr: a, wdata: d};
      if (p == 0) txq0.push_back(t);
      else        txq1.push_back(t);
   endtask

   task automatic step();
      logic [1:0] eg, ev;
      logic       o;
      tx_t        t;
      @(negedge clk);
      cyc++;
      if (cyc == resp_cycle) last_rdata[resp_owner] = resp_data;
      eg = '0;
      ev = '0;
      if (cyc == acc_cycle)  eg[acc_owner]  = 1'b1;
      if (cyc == resp_cycle) ev[resp_owner] = 1'b1;
      chk("gnt", {m1_gnt, m0_gnt}, eg);
      chk("rvalid", {m1_rvalid, m0_rvalid}, ev);
      chk("rdata", {m1_rdata, m0_rdata}, {last_rdata[1], last_rdata[0]});
      chk("mem_we", mem_we, (cyc == acc_cycle) && acc_we);
      if (cyc == acc_cycle) begin
         chk("mem_addr", mem_addr, acc_addr);
         if (acc_we) chk("mem_wd", mem_wd, acc_wdata);
      end
      chk("conflict_cnt", conflict_cnt, 16'(exp_cnt));
      chk("sat_cnt", s_conflict_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
      chk("sat_hs", {s_m1_gnt, s_m0_gnt, s_m1_rvalid, s_m0_rvalid, s_mem_we},
          {eg, ev, (cyc == acc_cycle) && acc_we});
      chk("sat_rdata", {s_m1_rdata, s_m0_rdata}, {last_rdata[1], last_rdata[0]});
      if (cyc == acc_cycle) chk("sat_mem", {s_mem_addr, s_mem_wd}, {acc_addr, acc_we ? acc_wdata : s_mem_wd});

      // Requester agents: hold until gnt is seen at an edge, sometimes scramble inputs once latched.
      for (int p = 0; p < 2; p++) begin
         if (done_pending[p]) active[p] = 0;
         done_pending[p] = (p == 0) ? m0_gnt : m1_gnt;
         if (done_pending[p] && ($urandom_range(3) == 0)) begin
            req_d[p]   = 1'b0;
            we_d[p]    = 1'($urandom);
            addr_d[p]  = $urandom;
            wdata_d[p] = $urandom;
         end
         if (!active[p]) begin
            if ((((p == 0) ? txq0.size() : txq1.size()) > 0) && ($urandom_range(99) < go_pct)) begin
               t = (p == 0) ? txq0.pop_front() : txq1.pop_front();
               req_d[p]   = 1'b1;
               we_d[p]    = t.we;
               addr_d[p]  = t.addr;
               wdata_d[p] = t.wdata;
               active[p]  = 1;
            end else begin
               req_d[p]   = 1'b0;
               we_d[p]    = 1'($urandom);
               addr_d[p]  = $urandom;
               wdata_d[p] = $urandom;
            end
         end
      end

      // Reference decision: arbiter free and someone asking -> serve per round-robin rule.
      if ((cyc >= next_free) && (req_d[0] || req_d[1])) begin
         if (req_d[0] && req_d[1]) begin
            o = ~last_gnt;
            exp_cnt++;
         end else begin
            o = req_d[1];
         end
         last_gnt  = o;
         acc_cycle = cyc + 1;
         acc_owner = o;
         acc_we    = we_d[o];
         acc_addr  = addr_d[o];
         acc_wdata = wdata_d[o];
         if (acc_we) begin
            smem[acc_addr[9:2]] = acc_wdata;
            next_free = cyc + 2;
         end else begin
            resp_cycle = cyc + 2;
            resp_owner = o;
            resp_data  = smem[acc_addr[9:2]];
            next_free  = cyc + 3;
         end
         $display("txn cyc=%0d port=%0d %s addr=%h data=%h", acc_cycle, o, acc_we ? "WR" : "RD",
                  acc_addr, acc_we ? acc_wdata : resp_data);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
         req_d[p] = 1'b0;
         active[p] = 0;
         done_pending[p] = 0;
         last_rdata[p] = '0;
      end
      txq0.delete();
      txq1.delete();
      #1;
      chk("rst_flags", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_we}, '0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, '0);
      chk("rst_mem", {mem_addr, mem_wd}, '0);
      chk("rst_cnt", {conflict_cnt, s_conflict_cnt}, '0);
      last_gnt   = 1'b1;
      exp_cnt    = 0;
      acc_cycle  = -1;
      resp_cycle = -1;
      repeat (2) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      next_free = cyc + 1;
   endtask

   task automatic drain(input int maxc);
      bit done;
      done = 0;
      for (int i = 0; i < maxc && !done; i++) begin
         step();
         done = (txq0.size() == 0) && (txq1.size() == 0) && !active[0] && !active[1] &&
                (cyc > resp_cycle) && (cyc > acc_cycle);
      end
      chk("drained", done, 1'b1);
   endtask

   initial begin
      logic [31:0] old80;
      bit hit;
      req_d = '0;
      we_d  = '0;
      for (int p = 0; p < 2; p++) begin
         addr_d[p]  = '0;
         wdata_d[p] = '0;
      end
      for (int i = 0; i < 256; i++) smem[i] = $urandom;
      smem[32'h10 >> 2] = 32'hDEADBEEF;
      for (int i = 0; i < 256; i++) mem[i] = smem[i];
      go_pct = 100;
      #2;

      // single read
      do_reset();
      push(0, 1'b0, 32'h10, 32'h0);
      drain(20);
      chk("single_read", m0_rdata, 32'hDEADBEEF);

      // tie straight after reset, then back-to-back contended writes
      do_reset();
      push(0, 1'b0, 32'h20, 32'h0);
      push(1, 1'b0, 32'h24, 32'h0);
      drain(20);
      chk("tie_cnt", conflict_cnt, 16'd1);
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b1, 32'h100 + 32'(i * 8), $urandom);
         push(1, 1'b1, 32'h104 + 32'(i * 8), $urandom);
      end
      drain(40);
      chk("sat_hold", s_conflict_cnt, 2'd3);

      // write by port 1, readback by port 0
      push(1, 1'b1, 32'h40, 32'hCAFEF00D);
      drain(20);
      push(0, 1'b0, 32'h40, 32'h0);
      drain(20);
      chk("readback", m0_rdata, 32'hCAFEF00D);

      // reset during the ACCESS cycle of a write
      old80 = smem[32'h80 >> 2];
      push(0, 1'b1, 32'h80, 32'h12345678);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step();
         hit = (cyc == acc_cycle);
      end
      chk("abort_reached", hit, 1'b1);
      do_reset();
      chk("abort_mem", mem[32'h80 >> 2], old80);
      smem[32'h80 >> 2] = old80;

      // randomized traffic
      go_pct = 40;
      for (int i = 0; i < 150; i++) begin
         push(0, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
         push(1, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
      end
      drain(4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory between the core load/store path (port 0) and a secondary master such as a program loader, debug port or DMA (port 1). Each access is sequenced through a small FSM: latch the request, drive the memory for one cycle, then return read data. Round-robin arbitration prevents either master from starving. A saturating counter records contention events for debug.

Parameters:
ADDR_W, 32, address width passed to memory
DATA_W, 32, data width
CNT_W, 16, width of contention counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
m0_req  in  1  port 0 access request; held until m0_gnt seen
m0_we  in  1  port 0 write enable (1=write, 0=read)
m0_addr  in  ADDR_W  port 0 address
m0_wdata  in  DATA_W  port 0 write data
m0_gnt  out  1  port 0 access performed this cycle
m0_rvalid  out  1  port 0 read data valid
m0_rdata  out  DATA_W  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  (same as port 0, for port 1)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wd  out  DATA_W  memory write data
mem_rd  in  DATA_W  memory combinational read data
conflict_cnt  out  CNT_W  number of arbitration decisions with both ports requesting

Behaviour:
- Reset (rst=0, async): state=IDLE; last_gnt=1 (so port 0 wins the first tie). Latched addr, wdata, we, owner=0. rdata regs=0. conflict_cnt=0. All gnt, rvalid and mem_we outputs=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req=1: select it.
  - If both req=1: select the port != last_gnt, and increment conflict_cnt (saturates at all-ones).
  - On selection, latch that port's addr/we/wdata plus owner at the edge, set last_gnt=owner, go to ACCESS.
  - If no req: stay in IDLE.
- ACCESS, exactly one cycle:
  - mem_addr=latched addr; mem_wd=latched wdata; mem_we=latched we.
  - gnt[owner]=1 combinationally from state. The other gnt=0.
  - On a read, capture mem_rd into the owner's rdata reg at the edge, then go to RESP.
  - On a write, go to IDLE.
- RESP, one cycle: rvalid[owner]=1 and rdata[owner] holds the captured value; then go to IDLE.
- rdata regs hold their value until the next read by the same port. rvalid is a one-cycle pulse.
- Outside ACCESS: mem_we=0. mem_addr and mem_wd show the latched values, which are don't-care to memory.
- Latency from req sampled in IDLE:
  - gnt asserts 1 cycle later.
  - rvalid asserts 2 cycles later.
  - Throughput: 3 cycles per read, 2 cycles per write.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until it samples gnt=1 at a rising edge.
  - After that edge it deasserts req, or keeps it high to issue a new request; req is only sampled in IDLE.
  - Inputs change after latching: ignored.
  - Req dropped after latching: access still completes (committed).
- Simultaneous continuous requests from both ports: grants alternate 0,1,0,1...
- Single continuous requester: served every access without waiting for the idle port.
- Reset asserted during ACCESS: state leaves ACCESS immediately, so mem_we and gnt drop asynchronously. A write in flight is aborted, and no rvalid is produced.
- Address is passed through unmodified. Alignment is the requester's responsibility.

Test Plan:
- Single read: mem[0x10]=0xDEADBEEF; m0_req, addr 0x10, we=0 -> m0_gnt high cycle 1 with mem_addr=0x10 and mem_we=0; m0_rvalid cycle 2 with m0_rdata=0xDEADBEEF; m1 outputs stay 0.
- Tie after reset: both req=1 (m0 read 0x20, m1 read 0x24), held until each is granted -> m0 granted first, m1 granted 3 cycles later; conflict_cnt=1.
- Continuous contention: both requesting back-to-back writes -> grant order 0,1,0,1; mem_we pulses every 2 cycles; conflict_cnt increments on every decision.
- Write then readback: m1 writes 0xCAFEF00D to 0x40, then m0 reads 0x40 -> m0_rdata=0xCAFEF00D; m1_rvalid never asserts.
- Reset mid-write: assert rst=0 during the ACCESS cycle of a write to 0x80 -> mem_we drops immediately, mem[0x80] unchanged, all outputs at reset values.
- Counter saturation with CNT_W=2: 5 contended decisions -> conflict_cnt reads 3 and holds.
